// File: rtl/edge_delay_pkg.sv
// Shared types and helpers for the gamma-aligned rising-edge delay array.
package edge_delay_pkg;

    // Per-channel lifecycle within one gamma cycle.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FIRE  = 2'd2,
        DONE  = 2'd3
    } ch_state_t;

    // Widest delay/counter width the fit check supports; callers zero-extend into it.
    localparam int MAX_DW = 16;

    // True when a spike sampled at time c with delay d starts its pulse no later
    // than the last cycle of the gamma window (c + 1 + d <= g_last). One extra
    // bit keeps the sum from wrapping.
    function automatic logic delay_fits(input logic [MAX_DW-1:0] c,
                                        input logic [MAX_DW-1:0] d,
                                        input logic [MAX_DW-1:0] g_last);
        logic [MAX_DW:0] sum;
        sum = {1'b0, c} + {1'b0, d} + (MAX_DW+1)'(1);
        return (sum <= {1'b0, g_last});
    endfunction

endpackage

// File: rtl/edge_delay_ch.sv
// One delay channel: detects the first rising edge of din within a gamma
// cycle and replays it as a PULSE_WIDTH pulse delay_q+1 cycles later, or
// flags a drop when the pulse would start past the gamma boundary.
module edge_delay_ch
    import edge_delay_pkg::*;
#(
    parameter int GAMMA_CYCLE_WIDTH = 128,
    parameter int PULSE_WIDTH       = 8,
    parameter int DW                = $clog2(GAMMA_CYCLE_WIDTH)
) (
    input  logic          aclk,
    input  logic          grst,
    input  logic          din,
    input  logic [DW-1:0] gcount,
    input  logic          boundary,
    input  logic [DW-1:0] delay_q,
    output logic          out,
    output logic          drop
);

    localparam int                  PW_W     = $clog2(PULSE_WIDTH + 1);
    localparam logic [PW_W-1:0]     PW_LAST  = PW_W'(PULSE_WIDTH - 1);
    localparam logic [PW_W-1:0]     PW_ONE   = PW_W'(1);
    localparam logic [DW-1:0]       D_ONE    = DW'(1);
    localparam logic [MAX_DW-1:0]   G_LAST_W = MAX_DW'(GAMMA_CYCLE_WIDTH - 1);

    ch_state_t       state, state_nxt;
    logic            in_q;
    logic [DW-1:0]   cnt, cnt_nxt;
    logic [PW_W-1:0] pcnt, pcnt_nxt;
    logic            out_nxt, drop_nxt;
    logic            spike;
    logic            fits;

    assign spike = din & ~in_q;
    assign fits  = delay_fits(MAX_DW'(gcount), MAX_DW'(delay_q), G_LAST_W);

    // State register plus registered outputs and counters; reset clears everything at once.
    always_ff @(posedge aclk or posedge grst) begin
        if (grst) begin
            state <= IDLE;
            in_q  <= 1'b0;
            cnt   <= '0;
            pcnt  <= '0;
            out   <= 1'b0;
            drop  <= 1'b0;
        end else begin
            state <= state_nxt;
            in_q  <= din;
            cnt   <= cnt_nxt;
            pcnt  <= pcnt_nxt;
            out   <= out_nxt;
            drop  <= drop_nxt;
        end
    end

    // Next-state logic; the gamma boundary overrides everything and rearms the channel.
    always_comb begin
        state_nxt = state;
        if (boundary) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (spike) begin
                        if (!fits)                state_nxt = DONE;
                        else if (delay_q == '0)   state_nxt = FIRE;
                        else                      state_nxt = ARMED;
                    end
                end
                ARMED:   if (cnt == '0)  state_nxt = FIRE;
                FIRE:    if (pcnt == '0) state_nxt = DONE;
                DONE:    state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Output and counter updates; cnt is loaded with d-1 so ARMED lasts exactly d cycles.
    always_comb begin
        out_nxt  = 1'b0;
        drop_nxt = 1'b0;
        cnt_nxt  = cnt;
        pcnt_nxt = pcnt;
        if (!boundary) begin
            case (state)
                IDLE: begin
                    if (spike) begin
                        if (!fits) begin
                            drop_nxt = 1'b1;
                        end else if (delay_q == '0) begin
                            out_nxt  = 1'b1;
                            pcnt_nxt = PW_LAST;
                        end else begin
                            cnt_nxt = delay_q - D_ONE;
                        end
                    end
                end
                ARMED: begin
                    if (cnt == '0) begin
                        out_nxt  = 1'b1;
                        pcnt_nxt = PW_LAST;
                    end else begin
                        cnt_nxt = cnt - D_ONE;
                    end
                end
                FIRE: begin
                    if (pcnt != '0) begin
                        out_nxt  = 1'b1;
                        pcnt_nxt = pcnt - PW_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/edge_delay_array.sv
// Multi-channel gamma-aligned rising-edge delay unit. Holds the shared gamma
// counter and the per-channel delay registers that are captured once per
// gamma cycle; the per-channel behaviour lives in edge_delay_ch.
module edge_delay_array
    import edge_delay_pkg::*;
#(
    parameter int NUM_CH            = 4,
    parameter int GAMMA_CYCLE_WIDTH = 128,
    parameter int PULSE_WIDTH       = 8,
    localparam int DW               = $clog2(GAMMA_CYCLE_WIDTH)
) (
    input  logic                 aclk,
    input  logic                 grst,
    input  logic [NUM_CH-1:0]    in,
    input  logic [NUM_CH*DW-1:0] delay,
    output logic [NUM_CH-1:0]    out,
    output logic [NUM_CH-1:0]    drop,
    output logic                 gamma_tick,
    output logic [DW-1:0]        gcount
);

    localparam logic [DW-1:0] G_LAST = DW'(GAMMA_CYCLE_WIDTH - 1);
    localparam logic [DW-1:0] G_ONE  = DW'(1);

    logic          boundary;
    logic [DW-1:0] delay_q [NUM_CH];

    assign boundary   = (gcount == G_LAST);
    assign gamma_tick = (gcount == '0);

    // Free-running gamma time; G is a power of two so it wraps naturally.
    always_ff @(posedge aclk or posedge grst) begin
        if (grst) gcount <= '0;
        else      gcount <= gcount + G_ONE;
    end

    // Capture per-channel delays only at the boundary so a gamma cycle sees one stable delay.
    always_ff @(posedge aclk or posedge grst) begin
        if (grst) begin
            for (int i = 0; i < NUM_CH; i++) delay_q[i] <= '0;
        end else if (boundary) begin
            for (int i = 0; i < NUM_CH; i++) delay_q[i] <= delay[i*DW +: DW];
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        edge_delay_ch #(
            .GAMMA_CYCLE_WIDTH (GAMMA_CYCLE_WIDTH),
            .PULSE_WIDTH       (PULSE_WIDTH),
            .DW                (DW)
        ) u_ch (
            .aclk     (aclk),
            .grst     (grst),
            .din      (in[ch]),
            .gcount   (gcount),
            .boundary (boundary),
            .delay_q  (delay_q[ch]),
            .out      (out[ch]),
            .drop     (drop[ch])
        );
    end

endmodule

// File: tb/tb_edge_delay_array.sv
// Scoreboard bench for edge_delay_array with G=16, PULSE_WIDTH=4, two channels.
// Each gamma cycle is described by hand-written 16-bit masks (bit c = gcount c)
// for the inputs and the expected out/drop waveforms.
module tb_edge_delay_array;

    localparam int NUM_CH = 2;
    localparam int G      = 16;
    localparam int PW     = 4;
    localparam int DW     = 4;

    typedef struct packed {
        logic [3:0] gc;
        logic       tick;
        logic [1:0] o;
        logic [1:0] d;
    } exp_t;

    logic                 aclk = 1'b0;
    logic                 grst = 1'b1;
    logic [NUM_CH-1:0]    in_v = '0;
    logic [NUM_CH*DW-1:0] delay_v = '0;
    logic [NUM_CH-1:0]    out;
    logic [NUM_CH-1:0]    drop;
    logic                 gamma_tick;
    logic [DW-1:0]        gcount;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    edge_delay_array #(
        .NUM_CH            (NUM_CH),
        .GAMMA_CYCLE_WIDTH (G),
        .PULSE_WIDTH       (PW)
    ) dut (
        .aclk       (aclk),
        .grst       (grst),
        .in         (in_v),
        .delay      (delay_v),
        .out        (out),
        .drop       (drop),
        .gamma_tick (gamma_tick),
        .gcount     (gcount)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every presented cycle against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge aclk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("gcount", 32'(gcount), 32'(e.gc));
                chk("gamma_tick", 32'(gamma_tick), 32'(e.tick));
                chk("out", 32'(out), 32'(e.o));
                chk("drop", 32'(drop), 32'(e.d));
            end
        end
    end

    task automatic reset_cycles(input logic [1:0] in_hold, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge aclk); #1;
            grst    = 1'b1;
            in_v    = in_hold;
            delay_v = '0;
            e = '{gc: 4'd0, tick: 1'b1, o: 2'b00, d: 2'b00};
            sb.push_back(e);
        end
    endtask

    // Drive one gamma cycle (or its first ncyc cycles) and queue the expected response.
    task automatic gamma(input logic [1:0][15:0] inm, input logic [1:0][15:0] outm,
                         input logic [1:0][15:0] dropm,
                         input logic [1:0][3:0] da, input logic [1:0][3:0] db,
                         input int chg, input int ncyc, input bit rel);
        exp_t e;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge aclk); #1;
            if (rel && c == 0) grst = 1'b0;
            in_v    = {inm[1][c], inm[0][c]};
            delay_v = (c < chg) ? da : db;
            e.gc   = 4'(c);
            e.tick = (c == 0);
            e.o    = {outm[1][c], outm[0][c]};
            e.d    = {dropm[1][c], dropm[0][c]};
            sb.push_back(e);
        end
    endtask

    initial begin
        // Reset with ch1 already high: counts as a spike at gcount 0.
        reset_cycles(2'b10, 3);

        // GC0 (delay_q 0,0): ch0 edge @2 d0 -> out 3..6; ch1 edge @0 d0 -> out 1..4.
        gamma({16'h0007, 16'h001C}, {16'h001E, 16'h0078}, {16'h0000, 16'h0000},
              {4'd0, 4'd5}, {4'd0, 4'd5}, 0, 16, 1'b1);
        // GC1 (5,0): ch0 edge @3 d5 -> out 9..12; ch1 idle.
        gamma({16'h0000, 16'h0038}, {16'h0000, 16'h1E00}, {16'h0000, 16'h0000},
              {4'd1, 4'd5}, {4'd1, 4'd5}, 0, 16, 1'b0);
        // GC2 (5,1): ch0 edge @10 d5 -> drop @11; ch1 edge @12 d1 -> out 14..15 truncated.
        gamma({16'h3000, 16'h0C00}, {16'hC000, 16'h0000}, {16'h0000, 16'h0800},
              {4'd1, 4'd1}, {4'd1, 4'd1}, 0, 16, 1'b0);
        // GC3 (1,1): ch0 edges @2,@6, held high to end, delay -> 7 at gcount 8;
        // ch1 edge @2 simultaneously; both out 4..7.
        gamma({16'h0004, 16'hFFCC}, {16'h00F0, 16'h00F0}, {16'h0000, 16'h0000},
              {4'd1, 4'd1}, {4'd0, 4'd7}, 8, 16, 1'b0);
        // GC4 (7,0): ch0 held high @0 is no edge; mid-cycle delay change ignored;
        // edge @5 d7 -> out 13..15; ch1 edge @14 d0 -> out 15 only.
        gamma({16'h4000, 16'h006F}, {16'h8000, 16'hE000}, {16'h0000, 16'h0000},
              {4'd7, 4'd0}, {4'd7, 4'd0}, 0, 16, 1'b0);
        // GC5 (0,7) up to gcount 10: ch0 edge @6 d0 -> out 7..10; ch1 edge @9 d7 -> drop @10.
        gamma({16'h0200, 16'h00C0}, {16'h0000, 16'h0780}, {16'h0400, 16'h0000},
              {4'd0, 4'd0}, {4'd0, 4'd0}, 0, 11, 1'b0);

        // Asynchronous reset while out/drop are high.
        @(negedge aclk); #2;
        grst = 1'b1;
        #1;
        chk("async_out", 32'(out), 32'h0);
        chk("async_drop", 32'(drop), 32'h0);
        chk("async_gcount", 32'(gcount), 32'h0);
        chk("async_tick", 32'(gamma_tick), 32'h1);
        reset_cycles(2'b00, 2);

        // GC6 after release (delay_q 0): ch0 edge @1 -> out 2..5.
        gamma({16'h0000, 16'h0006}, {16'h0000, 16'h003C}, {16'h0000, 16'h0000},
              {4'd0, 4'd0}, {4'd0, 4'd0}, 0, 16, 1'b1);

        // Let the monitor drain the scoreboard, bounded.
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge aclk);
        @(posedge aclk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, 0 required", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the run can never hang.
    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, finish required earlier");
        $fatal(1, "watchdog");
    end

endmodule
